// File: rtl/ftq_ctrl_pkg.sv
// FTQ controller shared constants and state encoding.
// Imported by the controller, its counter and the bus interface.
package ftq_ctrl_pkg;

  localparam int FTQ_CAP   = 64;
  localparam int FTQ_SLOTS = 65;
  localparam int FTQ_OCC_W = 7;
  localparam int FTQ_W     = 24;
  localparam int FTQ_HOLD  = 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_HOLD  = 2'd2
  } ftq_state_e;

endpackage

// File: rtl/ftq_ctrl_if.sv
// FTQ controller bus: predictor, fetch, redirect and FIFO strobes.
// slave = controller side, master = environment side.
interface ftq_ctrl_if
  import ftq_ctrl_pkg::*;
#(
  parameter int W = FTQ_W
);

  logic                 BpuValid;
  logic [W-1:0]         BpuEntry;
  logic                 BpuReady;
  logic                 FetchValid;
  logic [W-1:0]         FetchEntry;
  logic                 FetchReady;
  logic                 FetchStall;
  logic                 Redirect;
  logic                 FtqWable;
  logic [W-1:0]         FtqDin;
  logic                 FtqRable;
  logic                 FtqClean;
  logic                 FtqFull;
  logic [W-1:0]         FtqPreOut;
  logic [FTQ_OCC_W-1:0] Occupancy;
  logic                 Empty;
  logic                 OccErr;

  modport master (
    output BpuValid, BpuEntry,
    output FetchReady, FetchStall,
    output Redirect, FtqFull, FtqPreOut,
    input  BpuReady, FetchValid,
    input  FetchEntry, FtqWable,
    input  FtqDin, FtqRable, FtqClean,
    input  Occupancy, Empty, OccErr
  );

  modport slave (
    input  BpuValid, BpuEntry,
    input  FetchReady, FetchStall,
    input  Redirect, FtqFull, FtqPreOut,
    output BpuReady, FetchValid,
    output FetchEntry, FtqWable,
    output FtqDin, FtqRable, FtqClean,
    output Occupancy, Empty, OccErr
  );

endinterface

// File: rtl/ftq_occ_cnt.sv
// Up/down occupancy counter with clear, no wrap,
// and a sticky flag for count/full-flag disagreement.
module ftq_occ_cnt
  import ftq_ctrl_pkg::*;
#(
  parameter int CAP = FTQ_CAP
) (
  input  logic                 Clk,
  input  logic                 Rest,
  input  logic                 i_inc,
  input  logic                 i_dec,
  input  logic                 i_clr,
  input  logic                 i_chk,
  input  logic                 i_full,
  output logic [FTQ_OCC_W-1:0] o_occ,
  output logic                 o_err
);

  localparam logic [FTQ_OCC_W-1:0] CAP_V =
    FTQ_OCC_W'(CAP);

  logic [FTQ_OCC_W-1:0] r_occ;
  logic                 r_err;
  logic                 w_at_cap;
  logic                 w_at_zero;

  assign w_at_cap  = (r_occ == CAP_V);
  assign w_at_zero = (r_occ == '0);

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_occ <= '0;
      r_err <= 1'b0;
    end else begin
      if (i_clr) begin
        r_occ <= '0;
      end else if (i_inc && !i_dec) begin
        if (w_at_cap) r_err <= 1'b1;
        else          r_occ <= r_occ + 1'b1;
      end else if (i_dec && !i_inc) begin
        if (w_at_zero) r_err <= 1'b1;
        else           r_occ <= r_occ - 1'b1;
      end
      // FIFO full flag must track the count exactly
      if (i_chk && (i_full != w_at_cap))
        r_err <= 1'b1;
    end
  end

  assign o_occ = r_occ;
  assign o_err = r_err;

endmodule

// File: rtl/ftq_ctrl.sv
// FTQ sequencing controller: handshakes to FIFO strobes,
// occupancy tracking and redirect flush/hold recovery.
module ftq_ctrl
  import ftq_ctrl_pkg::*;
#(
  parameter int FIFOWIDE = FTQ_W,
  parameter int CAP      = FTQ_CAP,
  parameter int HOLD     = FTQ_HOLD
) (
  input logic       Clk,
  input logic       Rest,
  ftq_ctrl_if.slave bus
);

  localparam logic [FTQ_OCC_W-1:0] CAP_V =
    FTQ_OCC_W'(CAP);
  localparam logic [2:0] HOLD_LD = 3'(HOLD - 1);

  ftq_state_e           r_state;
  ftq_state_e           w_state_nxt;
  logic [2:0]           r_hold;
  logic [2:0]           w_hold_nxt;
  logic [FTQ_OCC_W-1:0] w_occ;
  logic [FIFOWIDE-1:0]  w_entry;
  logic                 w_run;
  logic                 w_go;
  logic                 w_bready;
  logic                 w_fvalid;
  logic                 w_wr;
  logic                 w_rd;
  logic                 w_flush;

  always_ff @(posedge Clk or negedge Rest) begin
    if (!Rest) begin
      r_state <= ST_RUN;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    unique case (r_state)
      ST_RUN: begin
        if (bus.Redirect) w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (bus.Redirect) begin
          w_state_nxt = ST_FLUSH;
        end else begin
          w_state_nxt = ST_HOLD;
          w_hold_nxt  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (bus.Redirect)
          w_state_nxt = ST_FLUSH;
        else if (r_hold == '0)
          w_state_nxt = ST_RUN;
        else
          w_hold_nxt = r_hold - 1'b1;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // Gate on Rest so nothing strobes while held in reset
  assign w_run   = Rest && (r_state == ST_RUN);
  assign w_go    = w_run && !bus.Redirect;
  assign w_flush = Rest && (r_state == ST_FLUSH);

  assign w_bready = w_go && !bus.FtqFull
                    && (w_occ < CAP_V);
  assign w_fvalid = w_go && !bus.FetchStall
                    && (w_occ != '0);
  assign w_wr     = bus.BpuValid && w_bready;
  assign w_rd     = w_fvalid && bus.FetchReady;
  assign w_entry  = bus.BpuEntry;

  ftq_occ_cnt #(.CAP(CAP)) u_occ (
    .Clk    (Clk),
    .Rest   (Rest),
    .i_inc  (w_wr),
    .i_dec  (w_rd),
    .i_clr  (w_flush),
    .i_chk  (w_run),
    .i_full (bus.FtqFull),
    .o_occ  (w_occ),
    .o_err  (bus.OccErr)
  );

  assign bus.BpuReady   = w_bready;
  assign bus.FetchValid = w_fvalid;
  assign bus.FtqWable   = w_wr;
  assign bus.FtqRable   = w_rd;
  assign bus.FtqClean   = w_flush;
  assign bus.FtqDin     = w_entry;
  assign bus.FetchEntry = bus.FtqPreOut;
  assign bus.Occupancy  = w_occ;
  assign bus.Empty      = (w_occ == '0);

endmodule
